// File: rtl/mem_access_unit.sv
// Load/store initiator for the 1024x32 single-port data memory: splits unaligned
// requests into one or two word accesses and realigns/extends read data.
module mem_access_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_UNSIGNED,
    input  logic [11:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        CEN,
    output logic        WEN,
    output logic [31:0] BWEN,
    output logic [9:0]  A,
    output logic [31:0] D,
    input  logic [31:0] Q
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC0 = 2'd1;
    localparam logic [1:0] S_ACC1 = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]  state;
    logic [11:0] addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic        err_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_buf;

    logic [3:0]  req_lanes;
    logic [31:0] req_d;
    logic [3:0]  hi_lanes;
    logic        split_q;
    logic [31:0] hi_d;
    logic [63:0] raw;
    logic [31:0] sh;
    logic [31:0] load_data;

    // Byte-lane mask across the two-word window starting at the low word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] expand_lanes(input logic [3:0] lanes);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{lanes[i]}};
        return r;
    endfunction

    assign REQ_READY = (state == S_IDLE) && !RST;

    assign req_lanes = 4'(lane_mask(REQ_SIZE, REQ_ADDR[1:0]));
    assign req_d     = REQ_WDATA << {REQ_ADDR[1:0], 3'b000};
    assign hi_lanes  = 4'(lane_mask(size_q, addr_q[1:0]) >> 4);
    assign split_q   = |hi_lanes;
    assign hi_d      = wdata_q >> (6'd32 - {1'b0, addr_q[1:0], 3'b000});

    always_comb begin
        raw = split_q ? {Q, lo_buf} : {32'b0, Q};
        sh  = 32'(raw >> {addr_q[1:0], 3'b000});
        case (size_q)
            2'b00:   load_data = uns_q ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_data = uns_q ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_data = sh;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
            lo_buf    <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
            CEN       <= 1'b0;
            WEN       <= 1'b1;
            BWEN      <= '0;
            A         <= '0;
            D         <= '0;
        end else begin
            RSP_VALID <= 1'b0;
            CEN       <= 1'b0;
            WEN       <= 1'b1;
            BWEN      <= '0;
            A         <= '0;
            D         <= '0;
            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        addr_q  <= REQ_ADDR;
                        size_q  <= REQ_SIZE;
                        we_q    <= REQ_WE;
                        uns_q   <= REQ_UNSIGNED;
                        wdata_q <= REQ_WDATA;
                        if (REQ_SIZE == 2'b11) begin
                            err_q <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            err_q <= 1'b0;
                            state <= S_ACC0;
                            CEN   <= 1'b1;
                            WEN   <= !REQ_WE;
                            A     <= REQ_ADDR[11:2];
                            if (REQ_WE) begin
                                D    <= req_d;
                                BWEN <= expand_lanes(req_lanes);
                            end
                        end
                    end
                end
                S_ACC0: begin
                    if (split_q) begin
                        state <= S_ACC1;
                        CEN   <= 1'b1;
                        WEN   <= !we_q;
                        A     <= addr_q[11:2] + 10'd1;
                        if (we_q) begin
                            D    <= hi_d;
                            BWEN <= expand_lanes(hi_lanes);
                        end
                    end else begin
                        state <= S_FIN;
                    end
                end
                S_ACC1: begin
                    lo_buf <= Q;
                    state  <= S_FIN;
                end
                default: begin
                    state     <= S_IDLE;
                    RSP_VALID <= 1'b1;
                    RSP_ERR   <= err_q;
                    RSP_RDATA <= (err_q || we_q) ? 32'b0 : load_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 1024x32 bit-masked memory.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_WE;
    logic [1:0]  REQ_SIZE;
    logic        REQ_UNSIGNED;
    logic [11:0] REQ_ADDR;
    logic [31:0] REQ_WDATA;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        CEN;
    logic        WEN;
    logic [31:0] BWEN;
    logic [9:0]  A;
    logic [31:0] D;
    logic [31:0] Q = 32'b0;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int seen;

    mem_access_unit dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .CEN(CEN), .WEN(WEN), .BWEN(BWEN), .A(A), .D(D), .Q(Q)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (CEN === 1'b1) begin
            if (WEN) Q <= mem[A];
            else     mem[A] <= (mem[A] & ~BWEN) | (D & BWEN);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [11:0] addr, input logic [31:0] wdata);
        REQ_WE       = we;
        REQ_SIZE     = size;
        REQ_UNSIGNED = uns;
        REQ_ADDR     = addr;
        REQ_WDATA    = wdata;
        REQ_VALID    = 1'b1;
        step();
        REQ_VALID    = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!RSP_VALID && n < 12);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size, input logic uns,
                            input logic [11:0] addr, input logic [31:0] exp, input int exp_lat);
        int l;
        issue(1'b0, size, uns, addr, 32'b0);
        wait_rsp(l);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_data"}, RSP_RDATA, exp);
        chk({tag, "_err"}, RSP_ERR, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'b0;
        RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00;
        REQ_UNSIGNED = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;

        // reset state
        step(); step();
        chk("rst_ready", REQ_READY, 0);
        chk("rst_cen", CEN, 0);
        chk("rst_wen", WEN, 1);
        chk("rst_bwen", BWEN, 0);
        chk("rst_a", A, 0);
        chk("rst_d", D, 0);
        chk("rst_rspv", RSP_VALID, 0);
        chk("rst_rdata", RSP_RDATA, 0);
        chk("rst_err", RSP_ERR, 0);
        RST = 1'b0;
        #1;
        chk("rel_ready", REQ_READY, 1);

        // aligned word store
        issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF);
        chk("sw_cen", CEN, 1);
        chk("sw_a", A, 4);
        chk("sw_wen", WEN, 0);
        chk("sw_bwen", BWEN, 32'hFFFFFFFF);
        chk("sw_d", D, 32'hDEADBEEF);
        chk("sw_ready_busy", REQ_READY, 0);
        wait_rsp(lat);
        chk("sw_lat", lat, 2);
        chk("sw_rdata", RSP_RDATA, 0);
        chk("sw_err", RSP_ERR, 0);
        chk("sw_ready_rsp", REQ_READY, 1);
        step();
        chk("sw_rsp_pulse", RSP_VALID, 0);
        chk("sw_rdata_hold", RSP_RDATA, 0);

        // loads from word 4 = DEADBEEF
        load_chk("lw", 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 2);
        chk("lw_bwen", BWEN, 0);
        load_chk("lb_s", 2'b00, 1'b0, 12'h013, 32'hFFFFFFDE, 2);
        load_chk("lb_u", 2'b00, 1'b1, 12'h013, 32'h000000DE, 2);
        load_chk("lh_s", 2'b01, 1'b0, 12'h010, 32'hFFFFBEEF, 2);
        load_chk("lh_u2", 2'b01, 1'b1, 12'h012, 32'h0000DEAD, 2);
        load_chk("lb_s0", 2'b00, 1'b0, 12'h010, 32'hFFFFFFEF, 2);
        load_chk("lb_s1", 2'b00, 1'b0, 12'h011, 32'hFFFFFFBE, 2);

        // split word store at 0x007
        issue(1'b1, 2'b10, 1'b0, 12'h007, 32'h11223344);
        chk("ss0_a", A, 1);
        chk("ss0_wen", WEN, 0);
        chk("ss0_bwen", BWEN, 32'hFF000000);
        chk("ss0_d", D, 32'h44000000);
        step();
        chk("ss1_cen", CEN, 1);
        chk("ss1_a", A, 2);
        chk("ss1_bwen", BWEN, 32'h00FFFFFF);
        chk("ss1_d", D, 32'h00112233);
        lat = 1;
        do begin step(); lat++; end while (!RSP_VALID && lat < 12);
        chk("ss_lat", lat, 3);
        chk("ss_mem1", mem[1], 32'h44000000);
        chk("ss_mem2", mem[2], 32'h00112233);
        load_chk("ls", 2'b10, 1'b0, 12'h007, 32'h11223344, 3);
        load_chk("lh_split", 2'b01, 1'b1, 12'h007, 32'h00003344, 3);

        // wrap-around half store at 0xFFF
        issue(1'b1, 2'b01, 1'b0, 12'hFFF, 32'h0000ABCD);
        chk("wr0_a", A, 10'd1023);
        chk("wr0_bwen", BWEN, 32'hFF000000);
        chk("wr0_d", D, 32'hCD000000);
        step();
        chk("wr1_a", A, 0);
        chk("wr1_bwen", BWEN, 32'h000000FF);
        chk("wr1_d", D, 32'h000000AB);
        lat = 1;
        do begin step(); lat++; end while (!RSP_VALID && lat < 12);
        chk("wr_lat", lat, 3);
        chk("wr_mem1023", mem[1023], 32'hCD000000);
        chk("wr_mem0", mem[0], 32'h000000AB);
        load_chk("lwrap_s", 2'b01, 1'b0, 12'hFFF, 32'hFFFFABCD, 3);
        load_chk("lwrap_u", 2'b01, 1'b1, 12'hFFF, 32'h0000ABCD, 3);

        // illegal size
        issue(1'b0, 2'b11, 1'b0, 12'h010, 32'h0);
        chk("ill_cen", CEN, 0);
        wait_rsp(lat);
        chk("ill_lat", lat, 1);
        chk("ill_err", RSP_ERR, 1);
        chk("ill_rdata", RSP_RDATA, 0);
        chk("ill_cen_rsp", CEN, 0);

        // aligned byte store, then word readback clears the error flag
        issue(1'b1, 2'b00, 1'b0, 12'h012, 32'h0000005A);
        chk("sb_bwen", BWEN, 32'h00FF0000);
        chk("sb_d", D, 32'h005A0000);
        wait_rsp(lat);
        chk("sb_lat", lat, 2);
        chk("sb_err", RSP_ERR, 0);
        load_chk("lw2", 2'b10, 1'b0, 12'h010, 32'hDE5ABEEF, 2);

        // request held while busy is accepted only after the response
        REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_UNSIGNED = 1'b0; REQ_ADDR = 12'h010;
        REQ_VALID = 1'b1;
        step();
        chk("hold_e0_ready", REQ_READY, 0);
        chk("hold_e0_cen", CEN, 1);
        step();
        chk("hold_fin_cen", CEN, 0);
        chk("hold_fin_rspv", RSP_VALID, 0);
        step();
        chk("hold_rspv", RSP_VALID, 1);
        chk("hold_ready", REQ_READY, 1);
        chk("hold_rdata", RSP_RDATA, 32'hDE5ABEEF);
        step();
        REQ_VALID = 1'b0;
        chk("hold2_cen", CEN, 1);
        chk("hold2_a", A, 4);
        wait_rsp(lat);
        chk("hold2_lat", lat, 2);
        chk("hold2_rdata", RSP_RDATA, 32'hDE5ABEEF);

        // reset during ACC1 of a split load
        issue(1'b0, 2'b10, 1'b0, 12'h007, 32'h0);
        step();
        chk("ab_acc1_a", A, 2);
        RST = 1'b1;
        step();
        chk("ab_cen", CEN, 0);
        chk("ab_rspv", RSP_VALID, 0);
        chk("ab_ready", REQ_READY, 0);
        chk("ab_rdata", RSP_RDATA, 0);
        RST = 1'b0;
        #1;
        chk("ab_rel_ready", REQ_READY, 1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (RSP_VALID || CEN) seen++;
        end
        chk("ab_quiet", seen, 0);
        load_chk("post_ab", 2'b10, 1'b0, 12'h007, 32'h11223344, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
